// File: rtl/weight_addr_sequencer.sv
// weight_addr_sequencer: walks ker/row/col over a weight volume, emitting LANES packed addresses per beat.
// Optional perf counters enabled by defining WEIGHT_ADDR_SEQ_PERF_EN.
module weight_addr_sequencer #(
  parameter int ADDR_W = 5,
  parameter int LANES  = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [ADDR_W-1:0]         i_cfg_row_last,
  input  logic [ADDR_W-1:0]         i_cfg_col_last,
  input  logic [ADDR_W-1:0]         i_cfg_ker_last,
  input  logic                      i_out_ready,
  output logic                      o_out_valid,
  output logic                      o_load_en,
  output logic [LANES-1:0]          o_lane_mask,
  output logic [LANES*ADDR_W-1:0]   o_row_out,
  output logic [LANES*ADDR_W-1:0]   o_col_out,
  output logic [LANES*ADDR_W-1:0]   o_ker_out,
  output logic                      o_busy,
  output logic                      o_done
`ifdef WEIGHT_ADDR_SEQ_PERF_EN
  ,
  output logic [15:0]               o_perf_beats,
  output logic [15:0]               o_perf_stalls
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_row, r_col, r_ker, r_row_last, r_col_last, r_ker_last;
  logic [ADDR_W:0] w_col_next;
  logic w_start, w_fire, w_row_wrap, w_row_end, w_ker_end, w_last;
  assign w_start     = (r_state == S_IDLE) & i_start;
  assign o_out_valid = r_state == S_RUN;
  assign o_busy      = r_state == S_RUN;
  assign o_done      = r_state == S_DONE;
  assign o_load_en   = o_out_valid & i_out_ready;
  assign w_fire      = o_load_en;
  // one extra bit so col_base+LANES past the top address is seen as a row wrap
  assign w_col_next  = {1'b0, r_col} + (ADDR_W+1)'(LANES);
  assign w_row_wrap  = w_col_next > {1'b0, r_col_last};
  assign w_row_end   = r_row == r_row_last;
  assign w_ker_end   = r_ker == r_ker_last;
  assign w_last      = w_row_wrap & w_row_end & w_ker_end;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  always_comb begin
    w_next = S_IDLE;
    w_next = r_state == S_IDLE ? (i_start ? S_RUN : S_IDLE) :
             r_state == S_RUN  ? (i_abort ? S_IDLE : (w_fire & w_last) ? S_DONE : S_RUN) :
             S_IDLE;
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_row <= '0;
      r_col <= '0;
      r_ker <= '0;
      r_row_last <= '0;
      r_col_last <= '0;
      r_ker_last <= '0;
    end else if (w_start) begin
      r_row <= '0;
      r_col <= '0;
      r_ker <= '0;
      r_row_last <= i_cfg_row_last;
      r_col_last <= i_cfg_col_last;
      r_ker_last <= i_cfg_ker_last;
    end else if (w_fire) begin
      r_col <= w_row_wrap ? '0 : w_col_next[ADDR_W-1:0];
      r_row <= w_row_wrap ? (w_row_end ? '0 : r_row + 1'b1) : r_row;
      r_ker <= (w_row_wrap & w_row_end) ? r_ker + 1'b1 : r_ker;
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ADDR_W:0] w_lane_col;
    assign w_lane_col = {1'b0, r_col} + (ADDR_W+1)'(i);
    assign o_lane_mask[i] = o_out_valid & (w_lane_col <= {1'b0, r_col_last});
    assign o_row_out[i*ADDR_W +: ADDR_W] = o_lane_mask[i] ? r_row : '0;
    assign o_col_out[i*ADDR_W +: ADDR_W] = o_lane_mask[i] ? w_lane_col[ADDR_W-1:0] : '0;
    assign o_ker_out[i*ADDR_W +: ADDR_W] = o_lane_mask[i] ? r_ker : '0;
  end
`ifdef WEIGHT_ADDR_SEQ_PERF_EN
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      o_perf_beats  <= '0;
      o_perf_stalls <= '0;
    end else if (w_start) begin
      o_perf_beats  <= '0;
      o_perf_stalls <= '0;
    end else begin
      if (w_fire && o_perf_beats != 16'hFFFF) o_perf_beats <= o_perf_beats + 1'b1;
      if (o_out_valid && !i_out_ready && o_perf_stalls != 16'hFFFF) o_perf_stalls <= o_perf_stalls + 1'b1;
    end
`endif
endmodule

// File: tb/tb_weight_addr_sequencer.sv
// tb_weight_addr_sequencer: directed scans of weight_addr_sequencer checked against hand values and a beat model.
module tb_weight_addr_sequencer;
  logic clk = 1'b0, rst, start, abort, ready;
  logic [4:0] rl, cl, kl;
  logic valid, load_en, busy, done;
  logic [3:0] mask;
  logic [19:0] row_out, col_out, ker_out;
`ifdef WEIGHT_ADDR_SEQ_PERF_EN
  logic [15:0] perf_beats, perf_stalls;
`endif
  int checks = 0, errors = 0;
  int beats, dones, stalls;
  logic [3:0] last_mask;
  logic [19:0] last_col, last_ker;

  weight_addr_sequencer #(.ADDR_W(5), .LANES(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_cfg_row_last(rl), .i_cfg_col_last(cl), .i_cfg_ker_last(kl),
    .i_out_ready(ready), .o_out_valid(valid), .o_load_en(load_en),
    .o_lane_mask(mask), .o_row_out(row_out), .o_col_out(col_out), .o_ker_out(ker_out),
    .o_busy(busy), .o_done(done)
`ifdef WEIGHT_ADDR_SEQ_PERF_EN
    , .o_perf_beats(perf_beats), .o_perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_beat(input int k, input int r, input int c, input int j,
                          output logic [3:0] m, output logic [19:0] rb, output logic [19:0] cb, output logic [19:0] kb);
    int bpr, cbase, rr, kk, col;
    bpr = (c + 4) / 4;
    cbase = (j % bpr) * 4;
    rr = (j / bpr) % (r + 1);
    kk = j / (bpr * (r + 1));
    m = '0; rb = '0; cb = '0; kb = '0;
    for (int i = 0; i < 4; i++) begin
      col = cbase + i;
      if (col <= c) begin
        m[i] = 1'b1;
        rb[i*5 +: 5] = rr[4:0];
        cb[i*5 +: 5] = col[4:0];
        kb[i*5 +: 5] = kk[4:0];
      end
    end
  endtask

  task automatic run_scan(input int k, input int r, input int c, input logic [3:0] rpat, input int abort_at);
    int cyc, last_load, total;
    logic [3:0] m;
    logic [19:0] rb, cb, kb;
    logic ab;
    total = (k + 1) * (r + 1) * ((c + 4) / 4);
    beats = 0; dones = 0; stalls = 0; cyc = 0; last_load = -10;
    @(negedge clk);
    kl = 5'(k); rl = 5'(r); cl = 5'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kl = 5'd7; rl = 5'd9; cl = 5'd2;
    while (cyc < 400) begin
      ready = rpat[cyc % 4];
      ab = abort_at >= 0 && beats == abort_at;
      abort = ab;
      #1;
      if (valid) begin
        exp_beat(k, r, c, beats, m, rb, cb, kb);
        check("mask", mask, m);
        check("row", row_out, rb);
        check("col", col_out, cb);
        check("ker", ker_out, kb);
        check("busy", busy, 1);
        if (!ready) stalls++;
      end
      if (done) begin
        dones++;
        check("done_busy", busy, 0);
        check("done_valid", valid, 0);
        check("done_gap", cyc - last_load, 1);
        check("done_beats", beats, total);
      end
      if (load_en) begin
        beats++;
        last_load = cyc;
        last_mask = mask; last_col = col_out; last_ker = ker_out;
      end
      @(negedge clk);
      cyc++;
      if (ab) begin
        abort = 1'b0;
        #1;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
          if (done) dones++;
          @(negedge clk);
        end
        break;
      end
      if (dones > 0) begin
        #1;
        check("post_done", {done, busy, valid}, 3'b000);
        break;
      end
    end
    if (cyc >= 400) check("timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; rl = '0; cl = '0; kl = '0;
    #1;
    check("rst_outs", {valid, load_en, busy, done, mask}, 8'h00);
    check("rst_bus", {row_out, col_out, ker_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_outs", {valid, busy, done}, 3'b000);

    run_scan(0, 0, 3, 4'b1111, -1);
    check("t1_beats", beats, 1);
    check("t1_dones", dones, 1);
    check("t1_mask", last_mask, 4'b1111);
    check("t1_col", last_col, {5'd3, 5'd2, 5'd1, 5'd0});
`ifdef WEIGHT_ADDR_SEQ_PERF_EN
    check("t1_perf_beats", perf_beats, 1);
    check("t1_perf_stalls", perf_stalls, 0);
`endif

    run_scan(1, 1, 5, 4'b1111, -1);
    check("t2_beats", beats, 8);
    check("t2_dones", dones, 1);
    check("t2_mask", last_mask, 4'b0011);
    check("t2_col", last_col, {10'd0, 5'd5, 5'd4});
    check("t2_ker", last_ker, {10'd0, 5'd1, 5'd1});

    run_scan(1, 1, 5, 4'b1001, -1);
    check("t3_beats", beats, 8);
    check("t3_dones", dones, 1);
    check("t3_stalls_seen", stalls > 0, 1);
`ifdef WEIGHT_ADDR_SEQ_PERF_EN
    check("t3_perf_beats", perf_beats, 8);
    check("t3_perf_stalls", perf_stalls, 32'(stalls));
`endif

    run_scan(0, 0, 31, 4'b1111, -1);
    check("t4_beats", beats, 8);
    check("t4_mask", last_mask, 4'b1111);
    check("t4_col", last_col, {5'd31, 5'd30, 5'd29, 5'd28});

    run_scan(1, 1, 5, 4'b1111, 2);
    check("t5_beats", beats, 3);
    check("t5_dones", dones, 0);
    run_scan(1, 1, 5, 4'b1111, -1);
    check("t5_rerun_beats", beats, 8);
    check("t5_rerun_dones", dones, 1);

    @(negedge clk);
    kl = 5'd1; rl = 5'd1; cl = 5'd5; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t6_pre_valid", valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {valid, load_en, busy, done, mask}, 8'h00);
    check("t6_rst_bus", {row_out, col_out, ker_out}, 0);
`ifdef WEIGHT_ADDR_SEQ_PERF_EN
    check("t6_perf_beats", perf_beats, 0);
    check("t6_perf_stalls", perf_stalls, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_scan(0, 1, 6, 4'b1111, -1);
    check("t6_beats", beats, 4);
    check("t6_dones", dones, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
